// File: rtl/skullfet_cell_tester.sv
`timescale 1ns / 1ps
// skullfet_cell_tester
//
// Stimulus/response controller for the skullfet inverter and NAND cells. It
// steps the cell inputs through all four input vectors, waits a programmable
// settle time, samples the (synchronised) cell outputs, compares them with
// the expected logic values and counts mismatches in a saturating counter.
//
// Optional build macro: SKULLFET_ERR_CAPTURE_EN adds first_err[3:0] =
// {valid, cell, v[1:0]} recording the first failing sample of a run
// (cell 0 = inverter, 1 = NAND; inverter wins a tie).
//
// Ports:
//   wb_clk_i   in   clock
//   wb_rst_i   in   asynchronous active-high reset
//   start      in   run request, sampled only while idle
//   loops      in   number of 4-vector passes (0 treated as 1), latched at start
//   inv_a      out  inverter cell input A
//   nand_a     out  NAND cell input A
//   nand_b     out  NAND cell input B
//   inv_y      in   inverter cell output (asynchronous)
//   nand_y     in   NAND cell output (asynchronous)
//   busy       out  run in progress
//   done       out  one-cycle pulse at end of run
//   err_count  out  saturating mismatch count of the last/current run
//   pass       out  last completed run had zero mismatches
//   first_err  out  first-mismatch record (SKULLFET_ERR_CAPTURE_EN only)

module skullfet_cell_tester #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOOP_WIDTH    = 8,
    parameter int unsigned ERR_WIDTH     = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start,
    input  logic [LOOP_WIDTH-1:0] loops,
    output logic                  inv_a,
    output logic                  nand_a,
    output logic                  nand_b,
    input  logic                  inv_y,
    input  logic                  nand_y,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  pass
`ifdef SKULLFET_ERR_CAPTURE_EN
    ,
    output logic [3:0]            first_err
`endif
);

    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StSample,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [1:0]            v_q, v_d;
    logic [LOOP_WIDTH-1:0] loop_q, loop_d;
    logic [LOOP_WIDTH-1:0] loops_lat_q, loops_lat_d;
    logic [SetW-1:0]       settle_q, settle_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic                  pass_q, pass_d;

    // Two-flop synchronisers for the asynchronous cell outputs.
    logic [1:0] inv_sync_q;
    logic [1:0] nand_sync_q;

    logic         inv_mis;
    logic         nand_mis;
    logic [1:0]   mis_cnt;
    logic [ERR_WIDTH:0] err_sum;

`ifdef SKULLFET_ERR_CAPTURE_EN
    logic [3:0] first_err_q, first_err_d;
`endif

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            v_q         <= '0;
            loop_q      <= '0;
            loops_lat_q <= '0;
            settle_q    <= '0;
            err_q       <= '0;
            pass_q      <= 1'b0;
            inv_sync_q  <= '0;
            nand_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            loop_q      <= loop_d;
            loops_lat_q <= loops_lat_d;
            settle_q    <= settle_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
            inv_sync_q  <= {inv_sync_q[0], inv_y};
            nand_sync_q <= {nand_sync_q[0], nand_y};
        end
    end

`ifdef SKULLFET_ERR_CAPTURE_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            first_err_q <= '0;
        end else begin
            first_err_q <= first_err_d;
        end
    end

    assign first_err = first_err_q;
`endif

    // ------------------------------------------------------------------
    // Compare logic
    // ------------------------------------------------------------------
    always_comb begin
        inv_mis  = inv_sync_q[1] != ~v_q[0];
        nand_mis = nand_sync_q[1] != ~(v_q[0] & v_q[1]);
        mis_cnt  = {1'b0, inv_mis} + {1'b0, nand_mis};
        err_sum  = {1'b0, err_q} + (ERR_WIDTH + 1)'(mis_cnt);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        loop_d      = loop_q;
        loops_lat_d = loops_lat_q;
        settle_d    = settle_q;
        err_d       = err_q;
        pass_d      = pass_q;
`ifdef SKULLFET_ERR_CAPTURE_EN
        first_err_d = first_err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    loops_lat_d = (loops == '0) ? LOOP_WIDTH'(1) : loops;
                    err_d       = '0;
                    pass_d      = 1'b0;
                    v_d         = '0;
                    loop_d      = '0;
`ifdef SKULLFET_ERR_CAPTURE_EN
                    first_err_d = '0;
`endif
                    state_d     = StDrive;
                end
            end

            StDrive: begin
                settle_d = '0;
                state_d  = StSettle;
            end

            StSettle: begin
                if (settle_q == SettleLast) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            StSample: begin
                // Saturate instead of wrapping when the sum carries out.
                if (err_sum[ERR_WIDTH]) begin
                    err_d = '1;
                end else begin
                    err_d = err_sum[ERR_WIDTH-1:0];
                end
`ifdef SKULLFET_ERR_CAPTURE_EN
                if (!first_err_q[3] && (inv_mis || nand_mis)) begin
                    first_err_d = {1'b1, ~inv_mis, v_q};
                end
`endif
                if (v_q != 2'd3) begin
                    v_d     = v_q + 2'd1;
                    state_d = StDrive;
                end else if (loop_q != loops_lat_q - 1'b1) begin
                    v_d     = '0;
                    loop_d  = loop_q + 1'b1;
                    state_d = StDrive;
                end else begin
                    state_d = StDone;
                end
            end

            StDone: begin
                pass_d  = (err_q == '0);
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state so reset clears them at once
    // ------------------------------------------------------------------
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        inv_a  = 1'b0;
        nand_a = 1'b0;
        nand_b = 1'b0;

        unique case (state_q)
            StDrive, StSettle, StSample: begin
                busy   = 1'b1;
                nand_a = v_q[0];
                nand_b = v_q[1];
                inv_a  = v_q[0];
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // pass reflects the just-completed run during the done cycle itself.
    assign pass      = (state_q == StDone) ? (err_q == '0) : pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_skullfet_cell_tester.sv
`timescale 1ns / 1ps
// Self-checking bench for skullfet_cell_tester. A second instance with a
// 4-bit error counter shares the stimulus to exercise saturation.

module tb_skullfet_cell_tester;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  loops = 8'd0;
    logic        inv_a, nand_a, nand_b, inv_y, nand_y;
    logic        busy, done, pass;
    logic [15:0] err_count;

    logic        inv_a_s, nand_a_s, nand_b_s, inv_y_s, nand_y_s;
    logic        busy_s, done_s, pass_s;
    logic [3:0]  err_count_s;

    logic        fault_inv = 1'b0;   // inverter output stuck at 0
    logic        fault_nand = 1'b0;  // NAND output stuck at 1

    int checks = 0;
    int failures = 0;

`ifdef SKULLFET_ERR_CAPTURE_EN
    logic [3:0] first_err, first_err_s;
`endif

    always #5 wb_clk_i = ~wb_clk_i;

    // Behavioural cell models with optional stuck faults.
    assign inv_y    = fault_inv ? 1'b0 : ~inv_a;
    assign nand_y   = fault_nand ? 1'b1 : ~(nand_a & nand_b);
    assign inv_y_s  = fault_inv ? 1'b0 : ~inv_a_s;
    assign nand_y_s = fault_nand ? 1'b1 : ~(nand_a_s & nand_b_s);

    skullfet_cell_tester #(
        .SETTLE_CYCLES(4),
        .LOOP_WIDTH   (8),
        .ERR_WIDTH    (16)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .start    (start),
        .loops    (loops),
        .inv_a    (inv_a),
        .nand_a   (nand_a),
        .nand_b   (nand_b),
        .inv_y    (inv_y),
        .nand_y   (nand_y),
        .busy     (busy),
        .done     (done),
        .err_count(err_count),
        .pass     (pass)
`ifdef SKULLFET_ERR_CAPTURE_EN
        ,
        .first_err(first_err)
`endif
    );

    skullfet_cell_tester #(
        .SETTLE_CYCLES(4),
        .LOOP_WIDTH   (8),
        .ERR_WIDTH    (4)
    ) dut_small (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .start    (start),
        .loops    (loops),
        .inv_a    (inv_a_s),
        .nand_a   (nand_a_s),
        .nand_b   (nand_b_s),
        .inv_y    (inv_y_s),
        .nand_y   (nand_y_s),
        .busy     (busy_s),
        .done     (done_s),
        .err_count(err_count_s),
        .pass     (pass_s)
`ifdef SKULLFET_ERR_CAPTURE_EN
        ,
        .first_err(first_err_s)
`endif
    );

    // Launches a run and measures it; k counts edges after the start edge.
    // drv holds {inv_a,nand_b,nand_a} seen in the settle phase of vectors 0..3.
    task automatic run(input logic [7:0] l, input int repulse_at, input int loops_change_at,
                       output int done_at, output int busy_cnt, output int done_cnt,
                       output logic [11:0] drv);
        int budget;
        budget   = 4 * ((l == 8'd0) ? 1 : int'(l)) * 6 + 12;
        done_at  = -1;
        busy_cnt = 0;
        done_cnt = 0;
        drv      = '0;
        @(negedge wb_clk_i);
        start = 1'b1;
        loops = l;
        @(posedge wb_clk_i);
        #1;
        start = 1'b0;
        for (int k = 0; k <= budget; k++) begin
            if (k > 0) begin
                @(posedge wb_clk_i);
                #1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            for (int i = 0; i < 4; i++) begin
                if (k == 6 * i + 2) drv[3*i +: 3] = {inv_a, nand_b, nand_a};
            end
            if (k == repulse_at) start = 1'b1;
            if (k == repulse_at + 1) start = 1'b0;
            if (k == loops_change_at) loops = 8'd7;
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
        checks++;
        if ({busy, done, inv_a, nand_a, nand_b, pass} !== 6'b0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b drv=%b%b%b pass=%b err=%0d want all 0",
                     busy, done, inv_a, nand_a, nand_b, pass, err_count);
        end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_pass_run();
        int da, bc, dc;
        logic [11:0] drv;
        run(8'd1, -10, -10, da, bc, dc, drv);
        checks++;
        if (da !== 24) begin
            failures++;
            $display("FAIL pass_done_at: got %0d want 24", da);
        end
        checks++;
        if (bc !== 24) begin
            failures++;
            $display("FAIL pass_busy_cycles: got %0d want 24", bc);
        end
        checks++;
        if (dc !== 1) begin
            failures++;
            $display("FAIL pass_done_pulses: got %0d want 1", dc);
        end
        checks++;
        if (drv !== 12'b111_010_101_000) begin
            failures++;
            $display("FAIL pass_drive_map: got %b want 111010101000", drv);
        end
        checks++;
        if (err_count !== 16'd0 || pass !== 1'b1) begin
            failures++;
            $display("FAIL pass_result: got err=%0d pass=%b want err=0 pass=1", err_count, pass);
        end
        checks++;
        if ({inv_a, nand_a, nand_b} !== 3'b000) begin
            failures++;
            $display("FAIL pass_idle_drive: got %b want 000", {inv_a, nand_a, nand_b});
        end
        // Results must hold while idle.
        repeat (5) @(posedge wb_clk_i);
        #1;
        checks++;
        if (err_count !== 16'd0 || pass !== 1'b1) begin
            failures++;
            $display("FAIL pass_hold: got err=%0d pass=%b want err=0 pass=1", err_count, pass);
        end
    endtask

    task automatic test_nand_stuck();
        int da, bc, dc;
        logic [11:0] drv;
        fault_nand = 1'b1;
        run(8'd1, -10, -10, da, bc, dc, drv);
        fault_nand = 1'b0;
        checks++;
        if (err_count !== 16'd1 || pass !== 1'b0) begin
            failures++;
            $display("FAIL nand_stuck: got err=%0d pass=%b want err=1 pass=0", err_count, pass);
        end
`ifdef SKULLFET_ERR_CAPTURE_EN
        checks++;
        if (first_err !== 4'b1111) begin
            failures++;
            $display("FAIL nand_first_err: got %b want 1111", first_err);
        end
`endif
    endtask

    task automatic test_inv_stuck();
        int da, bc, dc;
        logic [11:0] drv;
        fault_inv = 1'b1;
        run(8'd3, -10, -10, da, bc, dc, drv);
        fault_inv = 1'b0;
        checks++;
        if (da !== 72) begin
            failures++;
            $display("FAIL inv_done_at: got %0d want 72", da);
        end
        checks++;
        if (err_count !== 16'd6 || pass !== 1'b0) begin
            failures++;
            $display("FAIL inv_stuck: got err=%0d pass=%b want err=6 pass=0", err_count, pass);
        end
`ifdef SKULLFET_ERR_CAPTURE_EN
        checks++;
        if (first_err !== 4'b1000) begin
            failures++;
            $display("FAIL inv_first_err: got %b want 1000", first_err);
        end
`endif
    endtask

    task automatic test_saturate();
        int da, bc, dc;
        logic [11:0] drv;
        fault_inv = 1'b1;
        run(8'd10, -10, -10, da, bc, dc, drv);
        fault_inv = 1'b0;
        checks++;
        if (da !== 240) begin
            failures++;
            $display("FAIL sat_done_at: got %0d want 240", da);
        end
        checks++;
        if (err_count !== 16'd20) begin
            failures++;
            $display("FAIL sat_raw_count: got %0d want 20", err_count);
        end
        checks++;
        if (err_count_s !== 4'd15 || pass_s !== 1'b0) begin
            failures++;
            $display("FAIL sat_small: got err=%0d pass=%b want err=15 pass=0",
                     err_count_s, pass_s);
        end
    endtask

    task automatic test_loops_zero();
        int da, bc, dc;
        logic [11:0] drv;
        run(8'd0, -10, 3, da, bc, dc, drv);
        checks++;
        if (da !== 24 || dc !== 1) begin
            failures++;
            $display("FAIL loops_zero: got done_at=%0d pulses=%0d want 24 1", da, dc);
        end
        // Mid-run loops change (to 7 at k=3) must be ignored.
        run(8'd1, -10, 3, da, bc, dc, drv);
        checks++;
        if (da !== 24 || bc !== 24) begin
            failures++;
            $display("FAIL loops_change: got done_at=%0d busy=%0d want 24 24", da, bc);
        end
    endtask

    task automatic test_repulse();
        int da, bc, dc;
        logic [11:0] drv;
        run(8'd1, 10, -10, da, bc, dc, drv);
        checks++;
        if (da !== 24 || dc !== 1 || bc !== 24) begin
            failures++;
            $display("FAIL repulse: got done_at=%0d pulses=%0d busy=%0d want 24 1 24",
                     da, dc, bc);
        end
    endtask

    task automatic test_reset_mid_run();
        int da, bc, dc;
        int seen_done;
        logic [11:0] drv;
        fault_inv = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b1;
        loops = 8'd1;
        @(posedge wb_clk_i);
        #1;
        start = 1'b0;
        repeat (12) @(posedge wb_clk_i);
        #1;
        checks++;
        if (err_count !== 16'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_before_reset: got err=%0d busy=%b want err=1 busy=1",
                     err_count, busy);
        end
        #2;
        wb_rst_i = 1'b1;
        #1;
        checks++;
        if ({busy, done, inv_a, nand_a, nand_b, pass} !== 6'b0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL midrun_reset_outputs: got busy=%b done=%b drv=%b%b%b pass=%b err=%0d want 0",
                     busy, done, inv_a, nand_a, nand_b, pass, err_count);
        end
        fault_inv = 1'b0;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge wb_clk_i);
            #1;
            if (done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL midrun_no_done: got %0d pulses want 0", seen_done);
        end
        run(8'd1, -10, -10, da, bc, dc, drv);
        checks++;
        if (da !== 24 || err_count !== 16'd0 || pass !== 1'b1 || drv !== 12'b111_010_101_000) begin
            failures++;
            $display("FAIL midrun_rerun: got done_at=%0d err=%0d pass=%b drv=%b want 24 0 1 111010101000",
                     da, err_count, pass, drv);
        end
    endtask

    initial begin
        test_reset();
        test_pass_run();
        test_nand_stuck();
        test_inv_stuck();
        test_saturate();
        test_loops_zero();
        test_repulse();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/skullfet_cell_tester.md
Name: skullfet_cell_tester

Overview:
- On-chip stimulus/response controller for the skullfet inverter and NAND cells.
- Drives the cell inputs through every input vector and waits a programmable settle time.
- Samples the cell outputs through synchronisers, compares them against expected logic, and counts mismatches.
- Sits between the wrapper's control logic (logic analyzer/Wishbone-side registers) and the blackbox cells.

Parameters:
- SETTLE_CYCLES, 4: cycles between driving a vector and sampling it; legal minimum 3, which covers the 2-flop sync latency.
- LOOP_WIDTH, 8: width of the loops input.
- ERR_WIDTH, 16: width of the saturating error counter.

Ports:
- wb_clk_i  in  1: clock.
- wb_rst_i  in  1: reset, asynchronous, active-high.
- start  in  1: run request; sampled only in IDLE.
- loops  in  LOOP_WIDTH: number of full 4-vector passes; 0 is treated as 1; latched at start.
- inv_a  out  1: inverter cell input A.
- nand_a  out  1: NAND cell input A.
- nand_b  out  1: NAND cell input B.
- inv_y  in  1: inverter cell output Y; asynchronous.
- nand_y  in  1: NAND cell output Y; asynchronous.
- busy  out  1: run in progress.
- done  out  1: one-cycle pulse at end of run.
- err_count  out  ERR_WIDTH: mismatches in last or current run; saturating.
- pass  out  1: high when the last completed run had err_count==0.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; vector index, loop counter, settle counter and synchronisers cleared. Reset mid-run aborts with no done pulse.
- inv_y and nand_y each pass through a 2-flop synchroniser; compares use the synchronised values.
- Vector index v[1:0] runs 0,1,2,3. Drive mapping:
  - nand_a = v[0], nand_b = v[1], inv_a = v[0].
  - Expected: inv_y = ~v[0]; nand_y = ~(v[0]&v[1]).
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
  - IDLE: drive outputs 0, busy=0. When start=1 at an edge: latch loops (0→1), clear err_count, clear pass, v=0, loop=0, go to DRIVE.
  - DRIVE (1 cycle): drive outputs per v; busy=1; settle counter=0; go to SETTLE.
  - SETTLE (SETTLE_CYCLES cycles): hold drive values; count up; at count SETTLE_CYCLES-1 go to SAMPLE.
  - SAMPLE (1 cycle): compare both cells. err_count adds 0, 1 or 2 and saturates at all-ones; it never wraps.
    - If v!=3: v++ and go to DRIVE.
    - If v==3 and loop!=latched-1: v=0, loop++, go to DRIVE.
    - Otherwise go to DONE.
  - DONE (1 cycle): done=1, busy=0, pass=(err_count==0), drive outputs 0; go to IDLE.
- Timing:
  - busy is high from the cycle after start is sampled through the final SAMPLE cycle.
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - done asserts exactly 4*L*(SETTLE_CYCLES+2) cycles after the start-sampling edge, where L is the latched loop count.
- start while busy or in DONE is ignored; there is no queuing.
- err_count and pass hold their values in IDLE until the next accepted start.
- Changing loops mid-run has no effect.

Optional Feature:
- Macro: SKULLFET_ERR_CAPTURE_EN.
- When defined, adds output first_err[3:0] = {valid, cell, v[1:0]}, where cell is 0 for inverter and 1 for NAND.
  - Cleared at accepted start.
  - Loaded at the first mismatching SAMPLE of the run; if both cells fail the same vector, the inverter is recorded.
  - Held until the next start.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Correct behavioural cell models, SETTLE_CYCLES=4, loops=1, start pulse → busy for 24 cycles, done pulse 24 cycles after start edge, err_count=0, pass=1.
- nand_y stuck at 1, loops=1 → err_count=1 (vector 3 only), pass=0; with SKULLFET_ERR_CAPTURE_EN, first_err=4'b1111.
- inv_y stuck at 0, loops=3 → err_count=6 (vectors 0 and 2 fail each pass), pass=0; with SKULLFET_ERR_CAPTURE_EN, first_err=4'b1000.
- ERR_WIDTH=4, inv_y stuck at 0, loops=10 → 20 raw mismatches; err_count saturates at 15 and does not wrap; pass=0.
- loops=0 → run identical to loops=1 (done after 24 cycles). start re-pulsed at cycle 10 of a run → ignored, single done pulse.
- Assert wb_rst_i at cycle 12 of a run (asynchronously, between clock edges) → outputs 0 immediately, no done pulse. A following start runs normally from v=0.
